// File: rtl/freq_counter_pkg.sv
// rtl/freq_counter_pkg.sv - shared state encodings and default sizing for the frequency counter blocks
package freq_counter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;

  localparam int DEF_GATE_CYCLES   = 10_000_000;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int DEF_COUNT_W       = 24;

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// rtl/freq_gate_ctrl_gate_timer.sv - modulo-N gate window timer with clear and terminal-count flag
module gate_timer #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gate-window sequencer counting edge pulses per window
// Define FREQ_GATE_SAT_EN to saturate the edge counter instead of wrapping.
module freq_gate_ctrl
  import freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int COUNT_W       = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               edge_pulse,
  output logic [COUNT_W-1:0] count_value,
  output logic               count_valid,
  output logic               overflow,
  output logic               gate_active
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]         state;
  logic [SW-1:0]      settle_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] edge_next;
  logic               edge_carry;
  logic               sticky_ovf;
  logic               gate_tc;

  // Timer is held at zero outside COUNT so every window starts aligned.
  gate_timer #(.N(GATE_CYCLES)) u_gate_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state != ST_COUNT),
    .run   (state == ST_COUNT),
    .tc    (gate_tc)
  );

`ifdef FREQ_GATE_SAT_EN
  assign edge_carry = edge_pulse & (&edge_cnt);
  assign edge_next  = edge_carry ? edge_cnt : edge_cnt + COUNT_W'(edge_pulse);
`else
  assign {edge_carry, edge_next} = {1'b0, edge_cnt} + (COUNT_W + 1)'(edge_pulse);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      edge_cnt    <= '0;
      sticky_ovf  <= 1'b0;
      count_value <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state       <= ST_COUNT;
            gate_active <= 1'b1;
            edge_cnt    <= '0;
            sticky_ovf  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_COUNT: begin
          if (gate_tc) begin
            // Final gate cycle: its own edge is folded into the published result.
            count_value <= edge_next;
            overflow    <= sticky_ovf | edge_carry;
            count_valid <= 1'b1;
            edge_cnt    <= '0;
            sticky_ovf  <= 1'b0;
            if (!enable) begin
              state       <= ST_IDLE;
              gate_active <= 1'b0;
            end
          end else if (!enable) begin
            state       <= ST_IDLE;
            gate_active <= 1'b0;
          end else begin
            edge_cnt   <= edge_next;
            sticky_ovf <= sticky_ovf | edge_carry;
          end
        end
        default: begin
          state       <= ST_IDLE;
          gate_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
Gate-window sequencer for the frequency counter. Consumes the single-cycle leading-edge pulses from the edge detector, counts them over a fixed gate window of GATE_CYCLES clocks, then publishes the count with a one-cycle valid strobe. Windows run back-to-back with no dead time while enabled. A settle period after enable discards edges while the upstream edge history fills.

Parameters:
GATE_CYCLES, 10000000, gate window length in clk cycles (>=2)
SETTLE_CYCLES, 3, cycles after enable during which edge_pulse is ignored (>=1)
COUNT_W, 24, width of edge counter and published result

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
enable  in  1  level; 1 = run measurements continuously
edge_pulse  in  1  one-cycle leading-edge strobe from edge detector
count_value  out  COUNT_W  edges counted in last completed window
count_valid  out  1  one-cycle strobe, count_value/overflow updated this cycle
overflow  out  1  last completed window exceeded 2^COUNT_W-1 edges
gate_active  out  1  high while in COUNT

Behaviour:
- Reset (sync): state IDLE; count_value=0, count_valid=0, overflow=0, gate_active=0; internal gate/settle/edge counters and sticky overflow = 0.
- States: IDLE, SETTLE, COUNT. All outputs registered.
- IDLE: enable=1 -> SETTLE, settle counter cleared. Otherwise stay.
- SETTLE: SETTLE_CYCLES cycles; edge_pulse ignored. After last settle cycle -> COUNT with gate counter=0, edge counter=0. enable=0 -> IDLE.
- COUNT: gate_active=1 in each of exactly GATE_CYCLES cycles. Each cycle with edge_pulse=1 adds 1 to edge counter, including first and last gate cycles.
- Window end (gate counter == GATE_CYCLES-1): next edge count_value <= edge_cnt + edge_pulse; overflow <= sticky_ovf | carry-out of that add; count_valid=1 for exactly one cycle; edge counter, sticky overflow, gate counter clear; state stays COUNT if enable=1 (new window starts immediately, zero lost cycles), else IDLE.
- enable falls mid-window (not final cycle): next cycle IDLE, window discarded, no count_valid, count_value/overflow hold previous result. Re-enable passes SETTLE again.
- enable falls on final window cycle: result still published, then IDLE.
- Counter overflow (default): edge counter wraps modulo 2^COUNT_W; sticky overflow set on the wrap, reported with the window result.
- count_valid low in all cycles other than window completion.
- Reset mid-operation: reset dominates enable and edge_pulse; next cycle reset state; an in-flight window is lost.
- Gate counter width clog2(GATE_CYCLES); settle counter width clog2(SETTLE_CYCLES+1).

Optional Feature:
FREQ_GATE_SAT_EN
- Defined: edge counter saturates at all-ones instead of wrapping; overflow still set when an edge arrives at all-ones; published count_value = 2^COUNT_W-1.
- Undefined: wrap-around behaviour as above.

Decomposition:
- Shared package freq_counter_pkg: state encodings (IDLE/SETTLE/COUNT localparams), default GATE_CYCLES/SETTLE_CYCLES/COUNT_W constants, used also by display/readout blocks.
- One sub-module natural: gate_timer (modulo-N counter, clear input, terminal-count output); controller FSM and edge accumulator remain in freq_gate_ctrl.

Test Plan:
(All with GATE_CYCLES=16, SETTLE_CYCLES=3, COUNT_W=4.)
1. reset, then enable=1, edge_pulse every 4th cycle from the first COUNT cycle -> gate_active high for 16 cycles, then count_valid one cycle with count_value=4, overflow=0.
2. edge_pulse held 1 throughout COUNT -> default: count_value=0, overflow=1; with FREQ_GATE_SAT_EN: count_value=15, overflow=1.
3. Back-to-back windows, one edge only on final cycle of window 1 and one on first cycle of window 2 -> two count_valid strobes 16 cycles apart, each count_value=1; gate_active never drops.
4. Pulses only during the 3 SETTLE cycles -> first result count_value=0.
5. enable=0 at gate cycle 8 after a prior result of 4 -> IDLE next cycle, no count_valid, count_value stays 4, gate_active=0.
6. reset asserted mid-COUNT -> next cycle all outputs 0, state IDLE; with enable still 1, SETTLE re-entered once reset drops.
